// File: rtl/rtc_bus_ctrl.sv
// Two-phase RTC bus sequencer: turns a one-cycle PicoBlaze port request into
// an address phase and a data phase on the multiplexed RTC bus.
module rtc_bus_ctrl #(
    parameter int T_PH  = 4,
    parameter int T_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       act_rtc,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] dir,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    localparam logic [7:0] PH_LOAD  = 8'(T_PH - 1);
    localparam logic [7:0] GAP_LOAD = 8'(T_GAP - 1);
    localparam bit         GAP_EN   = (T_GAP != 0);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       op_wr, op_wr_n;
    logic [7:0] addr_q, addr_n, wdata_q, wdata_n;
    logic       sample_rd;

    logic       busy_n, done_n, cs_n_n, rd_n_n, wr_n_n, a_d_n, ad_oe_n;
    logic [7:0] ad_out_n;

    // Next-state, phase counter and request latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        op_wr_n   = op_wr;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        sample_rd = 1'b0;
        case (state)
            IDLE: begin
                if (act_rtc && (write_strobe || read_strobe)) begin
                    state_n = A_SETUP;
                    op_wr_n = write_strobe;
                    addr_n  = dir;
                    wdata_n = data_in;
                end
            end
            A_SETUP: begin
                state_n = A_STROBE;
                cnt_n   = PH_LOAD;
            end
            A_STROBE: begin
                if (cnt == 8'd0) state_n = A_HOLD;
                else             cnt_n   = cnt - 8'd1;
            end
            A_HOLD: begin
                if (GAP_EN) begin
                    state_n = GAP;
                    cnt_n   = GAP_LOAD;
                end else begin
                    state_n = D_SETUP;
                end
            end
            GAP: begin
                if (cnt == 8'd0) state_n = D_SETUP;
                else             cnt_n   = cnt - 8'd1;
            end
            D_SETUP: begin
                state_n = D_STROBE;
                cnt_n   = PH_LOAD;
            end
            D_STROBE: begin
                if (cnt == 8'd0) begin
                    state_n   = D_HOLD;
                    sample_rd = !op_wr;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            D_HOLD:  state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pin values are decoded from the upcoming state so every pin is a flop.
    always_comb begin
        busy_n   = (state_n != IDLE);
        done_n   = 1'b0;
        cs_n_n   = 1'b1;
        rd_n_n   = 1'b1;
        wr_n_n   = 1'b1;
        a_d_n    = 1'b0;
        ad_oe_n  = 1'b0;
        ad_out_n = ad_out;
        case (state_n)
            A_SETUP, A_HOLD: begin
                cs_n_n   = 1'b0;
                a_d_n    = 1'b1;
                ad_oe_n  = 1'b1;
                ad_out_n = addr_n;
            end
            A_STROBE: begin
                cs_n_n   = 1'b0;
                a_d_n    = 1'b1;
                ad_oe_n  = 1'b1;
                ad_out_n = addr_n;
                wr_n_n   = 1'b0;
            end
            D_SETUP, D_HOLD: begin
                cs_n_n  = 1'b0;
                ad_oe_n = op_wr_n;
                if (op_wr_n) ad_out_n = wdata_n;
            end
            D_STROBE: begin
                cs_n_n  = 1'b0;
                ad_oe_n = op_wr_n;
                if (op_wr_n) ad_out_n = wdata_n;
                wr_n_n  = !op_wr_n;
                rd_n_n  = op_wr_n;
            end
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            op_wr    <= 1'b0;
            addr_q   <= 8'd0;
            wdata_q  <= 8'd0;
            data_out <= 8'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            a_d      <= 1'b0;
            ad_oe    <= 1'b0;
            ad_out   <= 8'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            op_wr    <= op_wr_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            if (sample_rd) data_out <= ad_in;
            busy     <= busy_n;
            done     <= done_n;
            cs_n     <= cs_n_n;
            rd_n     <= rd_n_n;
            wr_n     <= wr_n_n;
            a_d      <= a_d_n;
            ad_oe    <= ad_oe_n;
            ad_out   <= ad_out_n;
        end
    end

endmodule
